mp_seq_ctrl: RTL and testbench
==============================

MP_SEQ_CTRL -- requirements
Module: mp_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  upstream has an instruction on instr_in.
REQ-005 instr_in  input  32  instruction: [5:0] opcode, [10:6] src1, [15:11] src2, [20:16] dest; [31:21] ignored.
REQ-006 instr_ready  output  1  controller can accept an instruction this cycle.
REQ-007 rf_raddr1, rf_raddr2  output  5 each  register-file read addresses.
REQ-008 rf_rdata1, rf_rdata2  input  32 each  register-file read data, valid one cycle after the address is presented.
REQ-009 alu_opcode  output  6  opcode driven to the combinational ALU.
REQ-010 alu_a, alu_b  output  32 each  ALU operands.
REQ-011 alu_result  input  32  ALU result, combinational from alu_opcode, alu_a and alu_b.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  5  register-file write address.
REQ-014 rf_wdata  output  32  register-file write data.
REQ-015 done  output  1  one-cycle pulse when an instruction retires or is rejected.
REQ-016 illegal  output  1  qualifies done: the instruction had an invalid opcode.
REQ-017 result  output  32  result of the last legal instruction.
REQ-018 retired_cnt  output  CNT_W  count of legal instructions written back.

Function
REQ-019 FSM states SHALL be IDLE, DECODE, READ, EXEC and WB.
REQ-020 instr_ready SHALL be 1 only in IDLE.
REQ-021 Handshake: on instr_valid&instr_ready at edge T, the controller SHALL latch instr_in and enter DECODE; instr_in is ignored in every other cycle.
REQ-022 Legal opcodes SHALL be exactly 1, 4, 5, 6, 7, 8, 9, 11, 12, 13 and 14; all others (0, 2, 3, 10, 15, >=16) are illegal.
REQ-023 DECODE, legal opcode: drive rf_raddr1=src1 and rf_raddr2=src2, then enter READ.
REQ-024 DECODE, illegal opcode: assert done=1 and illegal=1 for that cycle, do not assert rf_we, leave result and retired_cnt unchanged, and return to IDLE.
REQ-025 READ: latch rf_rdata1 and rf_rdata2 into operand registers, then enter EXEC.
REQ-026 EXEC: drive alu_a and alu_b from the operand registers and alu_opcode from the latched opcode, register alu_result, then enter WB.
REQ-027 WB, all of the following for exactly one cycle:
- rf_we=1, rf_waddr=dest, rf_wdata=registered result;
- done=1, illegal=0;
- result updated to the registered value;
- retired_cnt incremented;
- then return to IDLE.
REQ-028 Register 0 is hard-zero: when dest=0, the WB cycle SHALL force rf_we=0, while still updating done, result and retired_cnt.
REQ-029 Latency: a legal instruction accepted at edge T SHALL retire (done) in the cycle after edge T+4.
REQ-030 Throughput: the next instruction SHALL be acceptable no earlier than edge T+5; an illegal instruction allows the next acceptance at edge T+2.
REQ-031 retired_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-032 Outside their active states, rf_we, done and illegal SHALL be 0.
REQ-033 alu_opcode, alu_a and alu_b SHALL hold their last values outside EXEC.
REQ-034 No operand forwarding: each instruction's reads occur after the previous write completed, so back-to-back dependencies are correct by construction.

Reset
REQ-035 When rst_n=0, the controller SHALL immediately enter IDLE and force all outputs to 0, including result and retired_cnt (instr_ready becomes 1 on release).
REQ-036 Reset asserted in any state SHALL abort the in-flight instruction with no rf_we and no done.

Verification
REQ-037 ADD (opcode 6), src1=1, src2=2, dest=3, rf_rdata 0x1208/0x2D78 -> after edge T+4: rf_we=1, rf_waddr=3, rf_wdata=0x3F80, result=0x3F80, retired_cnt=1.
REQ-038 Opcode 2 accepted at T -> after edge T+1: done=1, illegal=1, rf_we=0, result unchanged; instr_ready=1 the cycle after.
REQ-039 instr_valid held high with three SUB instructions -> acceptances at edges T, T+5, T+10; instr_ready=0 in between; three done pulses.
REQ-040 rst_n pulled low during EXEC -> rf_we never asserts, all outputs 0, next instruction executes normally.
REQ-041 XOR (opcode 4) with dest=0 -> rf_we=0 in WB, done=1, result=src1^src2, retired_cnt incremented.
REQ-042 Preload retired_cnt to 0xFFFF by retiring 65535 legal instructions, retire one more -> retired_cnt=0x0000.

Source files
------------

// File: rtl/mp_seq_if.sv
// Bus bundle between the multi-cycle sequencer and its environment
// (instruction source, register file, ALU, status consumers).
interface mp_seq_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr_in;
  logic             instr_ready;
  logic [4:0]       rf_raddr1;
  logic [4:0]       rf_raddr2;
  logic [31:0]      rf_rdata1;
  logic [31:0]      rf_rdata2;
  logic [5:0]       alu_opcode;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             done;
  logic             illegal;
  logic [31:0]      result;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  instr_valid, instr_in, rf_rdata1, rf_rdata2, alu_result,
    output instr_ready, rf_raddr1, rf_raddr2, alu_opcode, alu_a, alu_b,
           rf_we, rf_waddr, rf_wdata, done, illegal, result, retired_cnt
  );

  modport slave (
    output instr_valid, instr_in, rf_rdata1, rf_rdata2, alu_result,
    input  instr_ready, rf_raddr1, rf_raddr2, alu_opcode, alu_a, alu_b,
           rf_we, rf_waddr, rf_wdata, done, illegal, result, retired_cnt
  );
endinterface

// File: rtl/mp_seq_ctrl.sv
// Five-state multi-cycle instruction sequencer: fetch handshake, decode,
// register read, ALU execute and write-back, all outputs registered.
module mp_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mp_seq_if.master bus
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
      6'd11, 6'd12, 6'd13, 6'd14: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t              state_q,    state_d;
  logic [OP_W-1:0]     op_q,       op_d;
  logic [ADDR_W-1:0]   src1_q,     src1_d;
  logic [ADDR_W-1:0]   src2_q,     src2_d;
  logic [ADDR_W-1:0]   dest_q,     dest_d;
  logic [ADDR_W-1:0]   raddr1_q,   raddr1_d;
  logic [ADDR_W-1:0]   raddr2_q,   raddr2_d;
  logic [OP_W-1:0]     alu_op_q,   alu_op_d;
  logic [DATA_W-1:0]   alu_a_q,    alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,    alu_b_d;
  logic [DATA_W-1:0]   alu_res_q,  alu_res_d;
  logic                rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                done_q,     done_d;
  logic                illegal_q,  illegal_d;
  logic [DATA_W-1:0]   result_q,   result_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;

  logic unused_instr_hi;
  assign unused_instr_hi = ^bus.instr_in[31:21];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dest_d     = dest_q;
    raddr1_d   = raddr1_q;
    raddr2_d   = raddr2_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_res_d  = alu_res_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    result_d   = result_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          op_d    = bus.instr_in[5:0];
          src1_d  = bus.instr_in[10:6];
          src2_d  = bus.instr_in[15:11];
          dest_d  = bus.instr_in[20:16];
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_legal(op_q)) begin
          raddr1_d = src1_q;
          raddr2_d = src2_q;
          state_d  = READ;
        end else begin
          done_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = IDLE;
        end
      end
      // Operand registers double as the ALU input registers, so the ALU
      // inputs only move on entry to EXEC and hold everywhere else.
      READ: begin
        alu_a_d  = bus.rf_rdata1;
        alu_b_d  = bus.rf_rdata2;
        alu_op_d = op_q;
        state_d  = EXEC;
      end
      EXEC: begin
        alu_res_d = bus.alu_result;
        state_d   = WB;
      end
      WB: begin
        rf_we_d    = (dest_q != '0);
        rf_waddr_d = dest_q;
        rf_wdata_d = alu_res_q;
        done_d     = 1'b1;
        result_d   = alu_res_q;
        cnt_d      = cnt_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears every register so an in-flight instruction is dropped
  // without a write-back or done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      dest_q     <= '0;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_res_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dest_q     <= dest_d;
      raddr1_q   <= raddr1_d;
      raddr2_q   <= raddr2_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_res_q  <= alu_res_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted and rises on release.
  assign bus.instr_ready = rst_n & (state_q == IDLE);
  assign bus.rf_raddr1   = raddr1_q;
  assign bus.rf_raddr2   = raddr2_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.result      = result_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_mp_seq_ctrl.sv
// Scoreboard bench for mp_seq_ctrl with a behavioural register file and ALU.
module tb_mp_seq_ctrl;
  // Narrow counter so the wrap-around is reached in a few hundred cycles.
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_t = 0;
  int   prev_t = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic             ill;
    logic             we;
    logic [4:0]       waddr;
    logic [31:0]      res;
    logic [CNT_W-1:0] cnt;
    int               edge_no;
  } exp_t;
  exp_t sb[$];

  logic [31:0] regs [32];

  mp_seq_if #(.CNT_W(CNT_W)) bus ();
  mp_seq_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      6'd1:    return a & b;
      6'd4:    return a ^ b;
      6'd5:    return a | b;
      6'd7:    return a - b;
      6'd8:    return a << b[4:0];
      6'd9:    return a >> b[4:0];
      default: return a + b;
    endcase
  endfunction

  assign bus.rf_rdata1  = regs[bus.rf_raddr1];
  assign bus.rf_rdata2  = regs[bus.rf_raddr2];
  assign bus.alu_result = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[1] <= 32'h0000_1208;
      regs[2] <= 32'h0000_2D78;
    end else if (bus.rf_we) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int s1, input int s2, input int d);
    logic [10:0] junk;
    junk = 11'h5A5;
    return {junk, d[4:0], s2[4:0], s1[4:0], op[5:0]};
  endfunction

  // Drives one instruction, waits for the handshake edge and queues the
  // expected retirement. instr_valid is left high for back-to-back use.
  task automatic issue(input logic [31:0] ins, input logic ill, input logic we,
                       input logic [4:0] wa, input logic [31:0] res,
                       input logic [CNT_W-1:0] cnt);
    int   waited;
    exp_t e;
    waited = 0;
    bus.instr_valid = 1'b1;
    bus.instr_in    = ins;
    while (bus.instr_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
      prev_t    = last_t;
      last_t    = cyc;
      e.ill     = ill;
      e.we      = we;
      e.waddr   = wa;
      e.res     = res;
      e.cnt     = cnt;
      e.edge_no = last_t + (ill ? 1 : 4);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.done && prev_done) chk("done_width", 64'd2, 64'd1);
      if (bus.rf_we && !bus.done) chk("we_without_done", 64'd1, 64'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_edge", 64'(cyc), 64'(e.edge_no));
          chk("illegal", 64'(bus.illegal), 64'(e.ill));
          chk("rf_we", 64'(bus.rf_we), 64'(e.we));
          if (e.we) begin
            chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.waddr));
            chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.res));
          end
          chk("result", 64'(bus.result), 64'(e.res));
          chk("retired_cnt", 64'(bus.retired_cnt), 64'(e.cnt));
        end
      end
    end
    prev_done = bus.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.instr_ready), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cnt", 64'(bus.retired_cnt), 64'd0);
    preload = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("ready_after_rst", 64'(bus.instr_ready), 64'd1);
    @(negedge clk);

    // ADD r3 = r1 + r2
    issue(enc(6, 1, 2, 3), 1'b0, 1'b1, 5'd3, 32'h3F80, 6'd1);
    bus.instr_valid = 1'b0;
    wait_drain();
    chk("alu_op_hold", 64'(bus.alu_opcode), 64'd6);
    chk("alu_a_hold", 64'(bus.alu_a), 64'h1208);
    chk("alu_b_hold", 64'(bus.alu_b), 64'h2D78);
    chk("reg3", 64'(regs[3]), 64'h3F80);

    // Back-to-back SUBs with dependencies, valid held high throughout
    issue(enc(7, 3, 1, 4), 1'b0, 1'b1, 5'd4, 32'h2D78, 6'd2);
    issue(enc(7, 4, 2, 5), 1'b0, 1'b1, 5'd5, 32'h0000, 6'd3);
    chk("sub2_spacing", 64'(last_t - prev_t), 64'd5);
    issue(enc(7, 1, 5, 6), 1'b0, 1'b1, 5'd6, 32'h1208, 6'd4);
    chk("sub3_spacing", 64'(last_t - prev_t), 64'd5);
    // Illegal opcodes: result and counter unchanged
    issue(enc(2, 1, 2, 9), 1'b1, 1'b0, 5'd0, 32'h1208, 6'd4);
    chk("ill_after_legal_spacing", 64'(last_t - prev_t), 64'd5);
    issue(enc(10, 1, 2, 9), 1'b1, 1'b0, 5'd0, 32'h1208, 6'd4);
    chk("ill_spacing", 64'(last_t - prev_t), 64'd2);
    issue(enc(63, 1, 2, 9), 1'b1, 1'b0, 5'd0, 32'h1208, 6'd4);
    chk("ill_spacing2", 64'(last_t - prev_t), 64'd2);
    // XOR into r0: no write, but retires
    issue(enc(4, 1, 2, 0), 1'b0, 1'b0, 5'd0, 32'h3F70, 6'd5);
    chk("legal_after_ill_spacing", 64'(last_t - prev_t), 64'd2);
    issue(enc(1, 1, 2, 7), 1'b0, 1'b1, 5'd7, 32'h0008, 6'd6);
    issue(enc(5, 1, 2, 8), 1'b0, 1'b1, 5'd8, 32'h3F78, 6'd7);
    issue(enc(12, 1, 2, 9), 1'b0, 1'b1, 5'd9, 32'h3F80, 6'd8);
    bus.instr_valid = 1'b0;
    wait_drain();
    chk("reg4", 64'(regs[4]), 64'h2D78);
    chk("reg5", 64'(regs[5]), 64'h0);
    chk("reg6", 64'(regs[6]), 64'h1208);
    chk("reg0", 64'(regs[0]), 64'h0);
    chk("reg7", 64'(regs[7]), 64'h0008);

    // Reset during EXEC aborts the instruction
    issue(enc(6, 1, 2, 10), 1'b0, 1'b1, 5'd10, 32'h3F80, 6'd9);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_ready", 64'(bus.instr_ready), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_cnt", 64'(bus.retired_cnt), 64'd0);
    chk("abort_alu_a", 64'(bus.alu_a), 64'd0);
    chk("abort_raddr1", 64'(bus.rf_raddr1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_we_rst", 64'(bus.rf_we | bus.done), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_we_post", 64'(bus.rf_we | bus.done), 64'd0);
    end
    chk("abort_reg10", 64'(regs[10]), 64'd0);
    issue(enc(6, 1, 2, 11), 1'b0, 1'b1, 5'd11, 32'h3F80, 6'd1);
    bus.instr_valid = 1'b0;
    wait_drain();
    chk("reg11", 64'(regs[11]), 64'h3F80);

    // Counter wrap: retire until 2^CNT_W-1, then one more
    for (int i = 2; i <= 64; i++) begin
      issue(enc(6, 1, 2, 12), 1'b0, 1'b1, 5'd12, 32'h3F80, CNT_W'(i));
    end
    bus.instr_valid = 1'b0;
    wait_drain();
    chk("cnt_wrapped", 64'(bus.retired_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
